// File: rtl/calc_disp_pkg.sv
// Shared types, segment constants and conversion helpers for calc_result_display.
package calc_disp_pkg;

  localparam int unsigned OP_W       = 8;
  localparam int unsigned BCD_DIGITS = 3;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned CONV_STEPS = 8;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_ENCODE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_DIGIT = 2'd0,
    SEL_BLANK = 2'd1,
    SEL_MINUS = 2'd2
  } seg_sel_e;

  // Non-decimal digit codes used to spell "Err"
  localparam logic [3:0] DIG_R = 4'hA;
  localparam logic [3:0] DIG_E = 4'hE;

  // Active-low patterns, bit0 = a .. bit6 = g
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_R     = 7'b0101111;

  // One calculator result as sampled on load
  typedef struct packed {
    logic [OP_W-1:0] result;
    logic            negative;
    logic            div_by_zero;
  } calc_in_t;

  // Unsigned magnitude of a (possibly two's complement) result
  function automatic logic [OP_W-1:0] magnitude(input calc_in_t in);
    return in.negative ? OP_W'(~in.result + 1'b1) : in.result;
  endfunction

  // One double-dabble step: add-3 correction, then shift {bcd, op} left by one
  function automatic logic [BCD_W+OP_W-1:0] dd_step(input logic [BCD_W-1:0] bcd,
                                                    input logic [OP_W-1:0]  op);
    logic [BCD_W-1:0] adj;
    adj = '0;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? 4'(bcd[i*4 +: 4] + 4'd3) : bcd[i*4 +: 4];
    end
    return {adj[BCD_W-2:0], op, 1'b0};
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational digit / blank / minus to seven-segment pattern with polarity select.
module seg7_encode
  import calc_disp_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0]       i_digit,
  input  seg_sel_e         i_sel,
  output logic [SEG_W-1:0] o_seg_c
);

  logic [SEG_W-1:0] w_pat;

  // Select the active-low glyph
  always_comb begin
    w_pat = SEG_BLANK;
    case (i_sel)
      SEL_MINUS: w_pat = SEG_MINUS;
      SEL_DIGIT: begin
        case (i_digit)
          4'd0:    w_pat = SEG_0;
          4'd1:    w_pat = SEG_1;
          4'd2:    w_pat = SEG_2;
          4'd3:    w_pat = SEG_3;
          4'd4:    w_pat = SEG_4;
          4'd5:    w_pat = SEG_5;
          4'd6:    w_pat = SEG_6;
          4'd7:    w_pat = SEG_7;
          4'd8:    w_pat = SEG_8;
          4'd9:    w_pat = SEG_9;
          DIG_E:   w_pat = SEG_E;
          DIG_R:   w_pat = SEG_R;
          default: w_pat = SEG_BLANK;
        endcase
      end
      default: w_pat = SEG_BLANK;
    endcase
  end

  assign o_seg_c = SEG_ACTIVE_LOW ? w_pat : ~w_pat;

endmodule

// File: rtl/calc_result_display.sv
// Calculator result display: serial double-dabble to BCD, then seven-segment
// encoding of sign / digits / "Err" onto HEX2..HEX0.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module calc_result_display
  import calc_disp_pkg::*;
#(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned NEG_MAX        = 99
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [OP_W-1:0]  result,
  input  logic             negative,
  input  logic             div_by_zero,
  output logic [SEG_W-1:0] HEX0,
  output logic [SEG_W-1:0] HEX1,
  output logic [SEG_W-1:0] HEX2,
  output logic             busy,
  output logic             valid
);

  localparam logic [SEG_W-1:0] BLANK_OUT = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  state_e           r_state;
  logic [OP_W-1:0]  r_op;
  logic [OP_W-1:0]  r_mag;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic             r_dz;
  logic             r_pend;
  calc_in_t         r_pend_in;
  logic [SEG_W-1:0] r_hex0, r_hex1, r_hex2;
  logic             r_busy;
  logic             r_valid;

  calc_in_t              w_live_in;
  calc_in_t              w_src_in;
  logic                  w_start;
  logic [OP_W-1:0]       w_src_mag;
  logic [BCD_W+OP_W-1:0] w_step;
  logic [3:0]            w_hund, w_tens, w_ones;
  logic [3:0]            w_dig2, w_dig1, w_dig0;
  seg_sel_e              w_sel2, w_sel1, w_sel0;
  logic [SEG_W-1:0]      w_seg2, w_seg1, w_seg0;

  assign w_live_in = '{result: result, negative: negative, div_by_zero: div_by_zero};

  // Start a conversion from IDLE, or chain straight on from ENCODE; the newest sample wins
  always_comb begin
    w_start  = 1'b0;
    w_src_in = w_live_in;
    if (r_state == ST_IDLE) begin
      w_start = load;
    end else if (r_state == ST_ENCODE) begin
      w_start = load | r_pend;
      if (!load) w_src_in = r_pend_in;
    end
  end

  assign w_src_mag = magnitude(w_src_in);
  assign w_step    = dd_step(r_bcd, r_op);
  assign w_hund    = r_bcd[11:8];
  assign w_tens    = r_bcd[7:4];
  assign w_ones    = r_bcd[3:0];

  // Choose glyphs for the three display positions
  always_comb begin
    w_dig2 = w_hund;
    w_dig1 = w_tens;
    w_dig0 = w_ones;
    w_sel2 = SEL_DIGIT;
    w_sel1 = SEL_DIGIT;
    w_sel0 = SEL_DIGIT;
    if (r_dz) begin
      w_dig2 = DIG_E;
      w_dig1 = DIG_R;
      w_dig0 = DIG_R;
    end else if (r_neg && (32'(r_mag) > NEG_MAX)) begin
      w_sel2 = SEL_MINUS;
      w_sel1 = SEL_MINUS;
      w_sel0 = SEL_MINUS;
    end else if (r_neg) begin
      w_sel2 = SEL_MINUS;
`ifdef LEADING_ZERO_BLANK_EN
      if (w_tens == 4'd0) w_sel1 = SEL_BLANK;
`endif
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      if (w_hund == 4'd0) w_sel2 = SEL_BLANK;
      if (w_hund == 4'd0 && w_tens == 4'd0) w_sel1 = SEL_BLANK;
`endif
    end
  end

  seg7_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg2 (.i_digit(w_dig2), .i_sel(w_sel2), .o_seg_c(w_seg2));
  seg7_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg1 (.i_digit(w_dig1), .i_sel(w_sel1), .o_seg_c(w_seg1));
  seg7_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg0 (.i_digit(w_dig0), .i_sel(w_sel0), .o_seg_c(w_seg0));

  // Control FSM, conversion datapath, pending buffer and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_mag     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_dz      <= 1'b0;
      r_pend    <= 1'b0;
      r_pend_in <= '0;
      r_hex0    <= BLANK_OUT;
      r_hex1    <= BLANK_OUT;
      r_hex2    <= BLANK_OUT;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: ;
        ST_CONVERT: begin
          {r_bcd, r_op} <= w_step;
          r_cnt         <= CNT_W'(r_cnt + 1'b1);
          if (r_cnt == CNT_W'(CONV_STEPS - 1)) r_state <= ST_ENCODE;
          if (load) begin
            r_pend    <= 1'b1;
            r_pend_in <= w_live_in;
          end
        end
        ST_ENCODE: begin
          r_hex2  <= w_seg2;
          r_hex1  <= w_seg1;
          r_hex0  <= w_seg0;
          r_valid <= 1'b1;
          r_pend  <= 1'b0;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_start) begin
        r_op    <= w_src_mag;
        r_mag   <= w_src_mag;
        r_neg   <= w_src_in.negative;
        r_dz    <= w_src_in.div_by_zero;
        r_bcd   <= '0;
        r_cnt   <= '0;
        r_state <= ST_CONVERT;
        r_busy  <= 1'b1;
      end
    end
  end

  assign HEX0  = r_hex0;
  assign HEX1  = r_hex1;
  assign HEX2  = r_hex2;
  assign busy  = r_busy;
  assign valid = r_valid;

endmodule
